// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 access codes, LSU state encoding and
// helpers for access legality and byte-lane enables.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    // funct3[1:0] carries the access width: 00 byte, 01 half, 10 word.
    function automatic logic lsu_access_ok(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] addr_lo);
        logic f3_ok;
        logic aligned;
        if (is_store)
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        case (f3[1:0])
            2'b10:   aligned = (addr_lo == 2'b00);
            2'b01:   aligned = !addr_lo[0];
            default: aligned = 1'b1;
        endcase
        return f3_ok && aligned;
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it per funct3.
module lsu_load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: forwards ALU results to writeback, or runs a load/store over a
// valid/grant data-memory port while stalling the upstream pipeline.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = riscv_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_alu_res,
    input  logic [XLEN-1:0]   ex_wdata,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              stall_o,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              fault_o
);

    lsu_state_t        state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              fault_q, fault_d;

    logic              is_mem;
    logic              access_ok;
    logic              accept_mem;
    logic [XLEN-1:0]   load_data;

    assign is_mem     = ex_mem_read | ex_mem_write;
    assign access_ok  = lsu_access_ok(ex_mem_write, ex_funct3, ex_alu_res[1:0]);
    assign accept_mem = (state_q == IDLE) && ex_valid && is_mem && access_ok;

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .data_o    (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            we_q       <= we_d;
            be_q       <= be_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_mem) state_d = REQ;
            REQ:     if (dmem_gnt) state_d = we_q ? IDLE : WAIT;
            WAIT:    if (dmem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured once at accept so they stay stable while gnt is pending.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        we_d       = we_q;
        be_d       = be_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        fault_d    = 1'b0;
        if (accept_mem) begin
            addr_d = ex_alu_res;
            f3_d   = ex_funct3;
            we_d   = ex_mem_write;
            rd_d   = ex_rd;
            be_d   = lsu_byte_en(ex_funct3, ex_alu_res[1:0]);
            case (ex_funct3[1:0])
                2'b00:   wdata_d = {(XLEN/8){ex_wdata[7:0]}};
                2'b01:   wdata_d = {(XLEN/16){ex_wdata[15:0]}};
                default: wdata_d = ex_wdata;
            endcase
        end
        if ((state_q == IDLE) && ex_valid) begin
            if (!is_mem) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = ex_rd;
                wb_data_d  = ex_alu_res;
            end else if (!access_ok) begin
                fault_d = 1'b1;
            end
        end else if ((state_q == WAIT) && dmem_rvalid) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_data;
        end
    end

    always_comb begin
        stall_o    = (state_q != IDLE);
        dmem_req   = (state_q == REQ);
        dmem_we    = dmem_req & we_q;
        dmem_addr  = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
        dmem_be    = dmem_req ? be_q : 4'b0000;
        dmem_wdata = dmem_req ? wdata_q : '0;
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign fault_o  = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: ALU passthrough, loads, stores, faults,
// reset mid-transaction and back-to-back issue under stall.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_res, ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall_o, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_funct3    (ex_funct3),
        .ex_alu_res   (ex_alu_res),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .stall_o      (stall_o),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .fault_o      (fault_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        ex_valid     = 1'b1;
        ex_mem_read  = rd_en;
        ex_mem_write = wr_en;
        ex_funct3    = f3;
        ex_alu_res   = addr;
        ex_wdata     = wd;
        ex_rd        = rd;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    // Load with immediate gnt and rvalid; checks the request and the extended result.
    task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        issue(1'b1, 1'b0, f3, addr, 32'h0, 5'd9);
        step();
        idle_ex();
        check_val({name, "_req"}, dmem_req, 1);
        check_val({name, "_we"}, dmem_we, 0);
        check_val({name, "_addr"}, dmem_addr, exp_addr);
        check_val({name, "_be"}, dmem_be, exp_be);
        check_val({name, "_stall_req"}, stall_o, 1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check_val({name, "_wait_req"}, dmem_req, 0);
        check_val({name, "_stall_wait"}, stall_o, 1);
        check_val({name, "_no_wb_early"}, wb_valid, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        step();
        dmem_rvalid = 1'b0;
        check_val({name, "_wb_valid"}, wb_valid, 1);
        check_val({name, "_wb_data"}, wb_data, exp_data);
        check_val({name, "_wb_rd"}, wb_rd, 9);
        check_val({name, "_stall_done"}, stall_o, 0);
        $display("txn %s addr=0x%08h -> wb_data=0x%08h", name, addr, wb_data);
    endtask

    task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int gnt_delay,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        issue(1'b0, 1'b1, f3, addr, wd, 5'd3);
        step();
        idle_ex();
        for (int i = 0; i <= gnt_delay; i++) begin
            check_val({name, "_req"}, dmem_req, 1);
            check_val({name, "_we"}, dmem_we, 1);
            check_val({name, "_addr"}, dmem_addr, exp_addr);
            check_val({name, "_be"}, dmem_be, exp_be);
            check_val({name, "_wdata"}, dmem_wdata, exp_wdata);
            check_val({name, "_stall"}, stall_o, 1);
            check_val({name, "_no_wb"}, wb_valid, 0);
            dmem_gnt = (i == gnt_delay);
            step();
        end
        dmem_gnt = 1'b0;
        check_val({name, "_done_req"}, dmem_req, 0);
        check_val({name, "_done_stall"}, stall_o, 0);
        check_val({name, "_done_no_wb"}, wb_valid, 0);
        $display("txn %s addr=0x%08h wdata=0x%08h gnt_delay=%0d", name, addr, wd, gnt_delay);
    endtask

    task automatic do_fault(input string name, input logic rd_en, input logic [2:0] f3,
                            input logic [31:0] addr);
        issue(rd_en, !rd_en, f3, addr, 32'h1111_2222, 5'd4);
        check_val({name, "_stall_pre"}, stall_o, 0);
        step();
        idle_ex();
        check_val({name, "_fault"}, fault_o, 1);
        check_val({name, "_req"}, dmem_req, 0);
        check_val({name, "_stall"}, stall_o, 0);
        check_val({name, "_no_wb"}, wb_valid, 0);
        step();
        check_val({name, "_fault_pulse"}, fault_o, 0);
        check_val({name, "_req_after"}, dmem_req, 0);
        $display("txn %s f3=%0d addr=0x%08h faulted", name, f3, addr);
    endtask

    initial begin
        reset       = 1'b1;
        ex_funct3   = 3'b000;
        ex_alu_res  = 32'h0;
        ex_wdata    = 32'h0;
        ex_rd       = 5'd0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        idle_ex();
        step();
        step();
        check_val("rst_stall", stall_o, 0);
        check_val("rst_req", dmem_req, 0);
        check_val("rst_addr", dmem_addr, 0);
        check_val("rst_wb_valid", wb_valid, 0);
        check_val("rst_fault", fault_o, 0);
        reset = 1'b0;
        step();

        // ALU passthrough
        issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        step();
        idle_ex();
        check_val("alu_wb_valid", wb_valid, 1);
        check_val("alu_wb_data", wb_data, 32'h0000_1234);
        check_val("alu_wb_rd", wb_rd, 5);
        check_val("alu_stall", stall_o, 0);
        check_val("alu_req", dmem_req, 0);
        step();
        check_val("alu_wb_pulse", wb_valid, 0);
        $display("txn ALU res=0x00001234 rd=5");

        do_load("LB",  3'b000, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0100, 4'b1000, 32'hFFFF_FF80);
        do_load("LBU", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0100, 4'b1000, 32'h0000_0080);
        do_load("LH",  3'b001, 32'h0000_0102, 32'h80FF_0000, 32'h0000_0100, 4'b1100, 32'hFFFF_80FF);
        do_load("LHU", 3'b101, 32'h0000_0102, 32'h80FF_0000, 32'h0000_0100, 4'b1100, 32'h0000_80FF);
        do_load("LH0", 3'b001, 32'h0000_0200, 32'h1234_7F01, 32'h0000_0200, 4'b0011, 32'h0000_7F01);
        do_load("LW",  3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF);

        do_store("SH", 3'b001, 32'h0000_0202, 32'h0000_ABCD, 3, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
        do_store("SB", 3'b000, 32'h0000_0101, 32'h1234_5678, 0, 32'h0000_0100, 4'b0010, 32'h7878_7878);
        do_store("SW", 3'b010, 32'h0000_0308, 32'hCAFE_F00D, 1, 32'h0000_0308, 4'b1111, 32'hCAFE_F00D);

        do_fault("LW_mis",  1'b1, 3'b010, 32'h0000_0301);
        do_fault("LH_mis",  1'b1, 3'b101, 32'h0000_0303);
        do_fault("LD_ill",  1'b1, 3'b011, 32'h0000_0300);
        do_fault("ST_ill",  1'b0, 3'b100, 32'h0000_0300);
        do_fault("SW_mis",  1'b0, 3'b010, 32'h0000_0302);

        // Reset while waiting for read data
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd6);
        step();
        idle_ex();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check_val("rstw_in_wait", stall_o, 1);
        reset = 1'b1;
        #1;
        check_val("rstw_stall", stall_o, 0);
        check_val("rstw_req", dmem_req, 0);
        check_val("rstw_wb_valid", wb_valid, 0);
        check_val("rstw_wb_data", wb_data, 0);
        step();
        reset       = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_AAAA;
        step();
        dmem_rvalid = 1'b0;
        check_val("rstw_late_rvalid", wb_valid, 0);
        check_val("rstw_idle", stall_o, 0);
        $display("txn reset-in-WAIT dropped pending load");

        // LW followed immediately by an ADD held under stall
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd8);
        step();
        issue(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd7);
        check_val("b2b_stall_req", stall_o, 1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check_val("b2b_stall_wait", stall_o, 1);
        check_val("b2b_no_add_wb", wb_valid, 0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0BAD_F00D;
        step();
        dmem_rvalid = 1'b0;
        check_val("b2b_lw_wb", wb_valid, 1);
        check_val("b2b_lw_data", wb_data, 32'h0BAD_F00D);
        check_val("b2b_lw_rd", wb_rd, 8);
        check_val("b2b_unstall", stall_o, 0);
        step();
        idle_ex();
        check_val("b2b_add_wb", wb_valid, 1);
        check_val("b2b_add_data", wb_data, 32'h0000_0055);
        check_val("b2b_add_rd", wb_rd, 7);
        step();
        check_val("b2b_quiet", wb_valid, 0);
        $display("txn LW 0x10 then ADD rd=7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
